// File: rtl/exc_ctrl.sv
// exc_ctrl: arbitrates exception/interrupt/ERET into CP0 update, flush and PC redirect
module exc_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int DRAIN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [4:0]  m_exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_eret,
    input  logic [5:0]  hw_int,
    input  logic [31:0] sr,
    input  logic [31:0] epc,
    output logic        cp0_req,
    output logic [4:0]  cp0_exc_code,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        exl_clr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [5:0]  int_sync,
    output logic        busy,
    output logic        exc_dropped
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
    state_t state, state_n;
    logic [3:0] cnt;
    logic [6*SYNC_STAGES-1:0] sync_q;
    logic ev, exc, irq, ret;
    logic cp0_req_d, exl_clr_d, drop_d, bd_d;
    logic [4:0] code_d;
    logic [31:0] epc_d, rpc_d;
    logic unused_sr;
    assign int_sync = sync_q[6*SYNC_STAGES-1 -: 6];
    assign busy = state != IDLE;
    assign unused_sr = ^{sr[31:16], sr[9:2]};
    assign ev = state == IDLE && m_valid;
    assign exc = ev && m_exc_code != 5'd0 && !sr[1];
    assign irq = ev && (|(int_sync & sr[15:10])) && sr[0] && !sr[1];
    assign ret = ev && m_eret && m_exc_code == 5'd0;
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    // an unreachable encoding falls back to IDLE rather than locking up
    always_comb begin
        state_n = state == IDLE ? ((exc || irq || ret) ? REDIRECT : IDLE)
                : state == REDIRECT ? DRAIN
                : (state == DRAIN && cnt != 4'd1) ? DRAIN : IDLE;
    end
    always_comb begin
        cp0_req_d = exc || irq;
        exl_clr_d = ret && !exc && !irq;
        drop_d = ev && m_exc_code != 5'd0 && sr[1];
        code_d = exc ? m_exc_code : irq ? 5'd0 : cp0_exc_code;
        epc_d = (exc || irq) ? (m_bd ? m_pc - 32'd4 : m_pc) : cp0_epc;
        bd_d = (exc || irq) ? m_bd : cp0_bd;
        rpc_d = (exc || irq) ? HANDLER_PC : ret ? epc : redirect_pc;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            cnt <= '0;
            cp0_req <= 1'b0;
            exl_clr <= 1'b0;
            exc_dropped <= 1'b0;
            cp0_exc_code <= '0;
            cp0_epc <= '0;
            cp0_bd <= 1'b0;
            redirect_pc <= '0;
            flush <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            sync_q <= {sync_q[6*SYNC_STAGES-7:0], hw_int};
            cnt <= state == REDIRECT ? 4'(DRAIN_CYCLES) : state == DRAIN ? cnt - 4'd1 : cnt;
            cp0_req <= cp0_req_d;
            exl_clr <= exl_clr_d;
            exc_dropped <= drop_d;
            cp0_exc_code <= code_d;
            cp0_epc <= epc_d;
            cp0_bd <= bd_d;
            redirect_pc <= rpc_d;
            flush <= state_n != IDLE;
            redirect_valid <= state_n == REDIRECT;
        end
    end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the P8 pipeline. Samples exception and ERET information from the M stage and synchronises the six device interrupt lines. It arbitrates between exception, interrupt and ERET, then drives a one-cycle update strobe into the CP0 register block. It also issues pipeline flush and PC-redirect commands, and holds off new events for a fixed drain window.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address
- DRAIN_CYCLES, 2, cycles spent in DRAIN after any redirect (1..15)
- SYNC_STAGES, 2, flops per hw_int synchroniser (2..3)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- m_valid  in  1  M stage holds a real (non-bubble) instruction
- m_exc_code  in  5  exception code of M instruction, 0 = none
- m_pc  in  32  PC of M instruction
- m_bd  in  1  M instruction is in a branch delay slot
- m_eret  in  1  M instruction is ERET
- hw_int  in  6  raw device interrupt levels
- sr  in  32  current CP0 SR (IM = [15:10], EXL = [1], IE = [0])
- epc  in  32  current CP0 EPC
- cp0_req  out  1  one-cycle strobe: CP0 latches code/EPC/BD and sets EXL
- cp0_exc_code  out  5  code to write (0 for interrupt)
- cp0_epc  out  32  EPC value, m_bd ? m_pc-4 : m_pc (mod 2^32)
- cp0_bd  out  1  BD flag to write
- exl_clr  out  1  one-cycle strobe: CP0 clears EXL (ERET)
- flush  out  1  kill F/D/E/M contents; high in REDIRECT and DRAIN
- redirect_valid  out  1  one-cycle strobe: load redirect_pc into PC
- redirect_pc  out  32  HANDLER_PC or epc
- int_sync  out  6  synchronised hw_int (CP0 Cause.IP source)
- busy  out  1  state != IDLE
- exc_dropped  out  1  one-cycle pulse: exception seen while EXL=1, ignored

## Operation
- States: IDLE, REDIRECT, DRAIN.
- int_sync: each bit passes through a SYNC_STAGES-flop chain and is not otherwise filtered.
- Event evaluation happens only in IDLE, with m_valid=1:
  - exc = (m_exc_code != 0) & ~sr[1]
  - irq = |(int_sync & sr[15:10]) & sr[0] & ~sr[1]
  - ret = m_eret & (m_exc_code == 0)
- Priority: exc > irq > ret. Only one event is taken per evaluation.
- exc or irq:
  - register cp0_exc_code (m_exc_code, or 0 for irq), cp0_epc and cp0_bd
  - redirect_pc = HANDLER_PC
  - go to REDIRECT
- ret: redirect_pc = epc (sampled that cycle); go to REDIRECT.
- (m_exc_code != 0) & sr[1] in IDLE with m_valid: pulse exc_dropped; no state change.
- REDIRECT (exactly 1 cycle):
  - redirect_valid = 1 and flush = 1
  - cp0_req = 1 for exc/irq; exl_clr = 1 for ret (never both)
  - load the drain counter with DRAIN_CYCLES, go to DRAIN
- DRAIN: flush = 1; decrement the counter each cycle; at 1, go to IDLE. M inputs are ignored.
- Interrupts arriving during REDIRECT/DRAIN stay pending in int_sync and are evaluated on the first valid IDLE cycle.
- All outputs are registered except busy and int_sync, which are direct state/flop outputs.

## Timing
- Reset (reset=0 at a clk edge):
  - state = IDLE, counter = 0, all sync flops = 0
  - every output = 0, including redirect_pc and cp0_epc
  - a reset during REDIRECT/DRAIN aborts with no further strobes
- Event at edge T (IDLE sample) → REDIRECT during T+1, with cp0_req/exl_clr/redirect_valid high for that single cycle. DRAIN occupies T+2 .. T+1+DRAIN_CYCLES; IDLE returns and evaluation resumes at T+2+DRAIN_CYCLES.
- Interrupt latency from hw_int rising to int_sync = SYNC_STAGES cycles. irq adds one sample cycle plus 1 to the REDIRECT strobe.
- exc_dropped is high during the cycle after the sample and never coincides with REDIRECT.
- m_valid=0 in IDLE: no event, no strobe; pending irq waits.
- cp0_epc wraps mod 2^32 (m_pc=0, m_bd=1 → 32'hFFFF_FFFC).

## Test plan
- Reset hold 3 cycles, then release:
  - all outputs 0; busy=0
  - with hw_int=6'h3F and sr=0, int_sync=6'h3F after SYNC_STAGES cycles
  - no cp0_req
- m_exc_code=5'd4, m_pc=32'h0000_3008, m_bd=0, sr=32'h0000_FC01, at edge T:
  - T+1: cp0_req=1, cp0_exc_code=4, cp0_epc=32'h3008, redirect_pc=32'h4180, flush=1
  - flush stays high through T+3; busy=0 at T+4
- hw_int[2]=1, sr=32'h0000_1001, m_valid=1, m_pc=32'h3010, m_bd=1:
  - cp0_req fires SYNC_STAGES+1 cycles after hw_int rises
  - cp0_exc_code=0, cp0_epc=32'h300C, cp0_bd=1
- Same cycle: m_exc_code=5'd10, m_eret=1, int pending → exception taken (code 10); no exl_clr.
- m_eret=1, epc=32'h0000_3100, sr EXL=1 → exl_clr and redirect_valid together, redirect_pc=32'h3100, cp0_req=0.
- Edge cases:
  - exception with sr[1]=1 → exc_dropped pulse, busy stays 0
  - reset=0 asserted mid-DRAIN → busy=0 and flush=0 the next cycle
